pulse_hs_rx: RTL and testbench

Single-clock receiving endpoint of the four-phase req/ack pulse-transfer protocol. It takes an asynchronous level request from a foreign clock domain, synchronizes it, presents exactly one event per request to local logic through a valid/ready handshake, and returns a level acknowledge. It sits in the destination domain of every cross-domain pulse path in the design, opposite the source-side req/ack generators.

---
 rtl/pulse_hs_pkg.sv | 13 +
 rtl/bit_sync.sv | 17 +
 rtl/pulse_hs_rx.sv | 80 ++++++++
 tb/tb_pulse_hs_rx.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/pulse_hs_pkg.sv
// pulse_hs_pkg: shared states and constants for the four-phase pulse-transfer endpoints
package pulse_hs_pkg;
  typedef enum logic [1:0] {IDLE, VALID, ACK} hs_rx_state_t;
  localparam int HS_SYNC_STAGES_DEF = 2;
  localparam int HS_CNT_W_DEF = 16;
  localparam int HS_SYNC_STAGES_MIN = 2;
  localparam int HS_SYNC_STAGES_MAX = 4;
  localparam logic HS_REQ_ACTIVE = 1'b1;
  localparam logic HS_ACK_ACTIVE = 1'b1;
  function automatic int hs_min_handshake(input int stages);
    return 2 * (stages + 1);
  endfunction
endpackage

// File: rtl/bit_sync.sv
// bit_sync: flop-chain synchronizer with asynchronous active-low reset to 0
module bit_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rstn,
  input  logic d,
  output logic q
);
  (* async_reg = "true" *) logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;
  always_comb sync_d = {sync_q[STAGES-2:0], d};
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) sync_q <= '0;
    else sync_q <= sync_d;
  assign q = sync_q[STAGES-1];
endmodule

// File: rtl/pulse_hs_rx.sv
// pulse_hs_rx: four-phase req/ack receiver presenting one valid/ready event per request
module pulse_hs_rx
  import pulse_hs_pkg::*;
#(
  parameter int SYNC_STAGES = HS_SYNC_STAGES_DEF,
  parameter int CNT_W = HS_CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             req_async,
  output logic             ack,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [CNT_W-1:0] evt_cnt,
  output logic             err_abort,
  input  logic             err_clr
);
  if (SYNC_STAGES < HS_SYNC_STAGES_MIN || SYNC_STAGES > HS_SYNC_STAGES_MAX)
    $error("pulse_hs_rx: SYNC_STAGES out of range");
  logic req_s;
  logic req_on;
  hs_rx_state_t state_q, state_d;
  logic ack_q, ack_d;
  logic [CNT_W-1:0] evt_cnt_q, evt_cnt_d;
  logic err_abort_q, err_abort_d;
  bit_sync #(.STAGES(SYNC_STAGES)) u_req_sync (
    .clk (clk),
    .rstn(rstn),
    .d   (req_async),
    .q   (req_s)
  );
  assign req_on = req_s == HS_REQ_ACTIVE;
  // Withdrawal in VALID outranks evt_ready; an abort also outranks err_clr.
  always_comb begin
    state_d = state_q;
    ack_d = ack_q;
    evt_cnt_d = evt_cnt_q;
    err_abort_d = err_clr ? 1'b0 : err_abort_q;
    unique case (state_q)
      IDLE: begin
        ack_d = ~HS_ACK_ACTIVE;
        state_d = req_on ? VALID : IDLE;
      end
      VALID: begin
        if (!req_on) begin
          state_d = IDLE;
          err_abort_d = 1'b1;
        end else if (evt_ready) begin
          state_d = ACK;
          ack_d = HS_ACK_ACTIVE;
          evt_cnt_d = evt_cnt_q + CNT_W'(1);
        end
      end
      ACK: begin
        state_d = req_on ? ACK : IDLE;
        ack_d = req_on ? HS_ACK_ACTIVE : ~HS_ACK_ACTIVE;
      end
      default: begin
        state_d = IDLE;
        ack_d = ~HS_ACK_ACTIVE;
      end
    endcase
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state_q <= IDLE;
      ack_q <= 1'b0;
      evt_cnt_q <= '0;
      err_abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ack_q <= ack_d;
      evt_cnt_q <= evt_cnt_d;
      err_abort_q <= err_abort_d;
    end
  assign ack = ack_q;
  assign evt_valid = state_q == VALID;
  assign evt_cnt = evt_cnt_q;
  assign err_abort = err_abort_q;
endmodule

// File: tb/tb_pulse_hs_rx.sv
// tb_pulse_hs_rx: directed checks of the pulse_hs_rx handshake, abort, wrap and reset behaviour
module tb_pulse_hs_rx;
  localparam int CW = 4;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic req_async = 1'b0;
  logic evt_ready = 1'b0;
  logic err_clr = 1'b0;
  logic ack, evt_valid, err_abort;
  logic [CW-1:0] evt_cnt;
  int n_cmp = 0;
  int n_bad = 0;
  pulse_hs_rx #(.SYNC_STAGES(2), .CNT_W(CW)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .req_async(req_async),
    .ack      (ack),
    .evt_valid(evt_valid),
    .evt_ready(evt_ready),
    .evt_cnt  (evt_cnt),
    .err_abort(err_abort),
    .err_clr  (err_clr)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic wait_ack(input logic v);
    int k = 0;
    while (ack !== v && k < 20) begin
      tick();
      k++;
    end
    check("wait_ack", 32'(ack), 32'(v));
  endtask
  task automatic do_reset();
    rstn = 1'b0;
    tick(2);
    rstn = 1'b1;
    tick();
  endtask
  initial begin
    tick(2);
    check("rst_ack", 32'(ack), 0);
    check("rst_valid", 32'(evt_valid), 0);
    check("rst_cnt", 32'(evt_cnt), 0);
    check("rst_err", 32'(err_abort), 0);
    rstn = 1'b1;
    tick();
    // basic handshake
    evt_ready = 1'b1;
    req_async = 1'b1;
    tick(2);
    check("t1_valid_early", 32'(evt_valid), 0);
    tick();
    check("t1_valid", 32'(evt_valid), 1);
    check("t1_ack_pre", 32'(ack), 0);
    tick();
    check("t1_valid_drop", 32'(evt_valid), 0);
    check("t1_ack", 32'(ack), 1);
    check("t1_cnt", 32'(evt_cnt), 1);
    req_async = 1'b0;
    tick(2);
    check("t1_ack_hold", 32'(ack), 1);
    tick();
    check("t1_ack_fall", 32'(ack), 0);
    // backpressure
    evt_ready = 1'b0;
    req_async = 1'b1;
    tick(3);
    for (int i = 0; i < 10; i++) begin
      check("t2_valid", 32'(evt_valid), 1);
      check("t2_ack", 32'(ack), 0);
      tick();
    end
    evt_ready = 1'b1;
    tick();
    check("t2_ack", 32'(ack), 1);
    check("t2_valid_drop", 32'(evt_valid), 0);
    check("t2_cnt", 32'(evt_cnt), 2);
    req_async = 1'b0;
    evt_ready = 1'b0;
    tick(3);
    check("t2_ack_fall", 32'(ack), 0);
    // abort
    req_async = 1'b1;
    tick(3);
    check("t3_valid", 32'(evt_valid), 1);
    tick(2);
    req_async = 1'b0;
    tick(2);
    check("t3_valid_hold", 32'(evt_valid), 1);
    check("t3_err_pre", 32'(err_abort), 0);
    tick();
    check("t3_valid_drop", 32'(evt_valid), 0);
    check("t3_err", 32'(err_abort), 1);
    check("t3_cnt", 32'(evt_cnt), 2);
    check("t3_ack", 32'(ack), 0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("t3_err_clr", 32'(err_abort), 0);
    // clear coincident with abort detection
    req_async = 1'b1;
    tick(3);
    check("t6_valid", 32'(evt_valid), 1);
    req_async = 1'b0;
    tick(2);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("t6_err_set_wins", 32'(err_abort), 1);
    tick();
    check("t6_err_sticky", 32'(err_abort), 1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("t6_err_clr", 32'(err_abort), 0);
    // 17 handshakes with a 4-bit counter, then a stuck request
    do_reset();
    evt_ready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      req_async = 1'b1;
      wait_ack(1'b1);
      check("t4_cnt", 32'(evt_cnt), 32'((i + 1) % 16));
      req_async = 1'b0;
      wait_ack(1'b0);
    end
    check("t4_cnt17", 32'(evt_cnt), 1);
    req_async = 1'b1;
    tick(50);
    check("t4_stuck_cnt", 32'(evt_cnt), 2);
    check("t4_stuck_ack", 32'(ack), 1);
    check("t4_stuck_valid", 32'(evt_valid), 0);
    // reset while acknowledging
    #1;
    rstn = 1'b0;
    #1;
    check("t5_ack_async", 32'(ack), 0);
    check("t5_cnt_rst", 32'(evt_cnt), 0);
    tick(2);
    rstn = 1'b1;
    tick(2);
    check("t5_valid_early", 32'(evt_valid), 0);
    tick();
    check("t5_valid", 32'(evt_valid), 1);
    tick();
    check("t5_ack", 32'(ack), 1);
    check("t5_cnt", 32'(evt_cnt), 1);
    req_async = 1'b0;
    wait_ack(1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
